// File: rtl/fifo_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter_if
//  Function : Producer / FIFO-write bundle shared by the write-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_ready;
  logic                wfull;
  logic                winc;
  logic [DW-1:0]       wdata;
  logic [GW-1:0]       grant_id;
  logic                busy;

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter
//  Function : Round-robin, packet-locked write-port arbiter for the async FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                 wclk,
  input  logic                 wrst,
  fifo_write_arbiter_if.slave  bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [GW-1:0] pick, idx;
  logic          found;
  logic          beat;

  // Rotating priority search starting just after the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = GW'((int'(last_q) + i) % N_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    beat_d        = beat_q;
    beat          = 1'b0;
    bus.req_ready = '0;
    bus.winc      = 1'b0;
    bus.wdata     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_BURST;
          grant_d = pick;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        bus.req_ready[grant_q] = ~bus.wfull;
        beat                   = bus.req_valid[grant_q] & ~bus.wfull;
        bus.winc               = beat;
        bus.wdata              = bus.req_data[int'(grant_q)*DW +: DW];
        // A stalled or idle cycle never ends the packet; only accepted beats do.
        if (beat) begin
          if (beat_q != CW'(MAX_BURST)) beat_d = beat_q + CW'(1);
          if (bus.req_last[grant_q] || (beat_q == CW'(MAX_BURST - 1))) begin
            state_d = S_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q == S_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_write_arbiter
//  Function : Vector-table bench for fifo_write_arbiter (default and cap-4 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  valid;
  logic [3:0]  last;
  logic [31:0] data;
  logic        wfull;

  fifo_write_arbiter_if #(.N_REQ(4), .DW(8)) bus_m ();
  fifo_write_arbiter_if #(.N_REQ(4), .DW(8)) bus_c ();

  assign bus_m.req_valid = valid;
  assign bus_m.req_last  = last;
  assign bus_m.req_data  = data;
  assign bus_m.wfull     = wfull;
  assign bus_c.req_valid = valid;
  assign bus_c.req_last  = last;
  assign bus_c.req_data  = data;
  assign bus_c.wfull     = wfull;

  fifo_write_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(16)) u_dut (
    .wclk (clk),
    .wrst (rst),
    .bus  (bus_m)
  );

  fifo_write_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4)) u_cap (
    .wclk (clk),
    .wrst (rst),
    .bus  (bus_c)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        wf;
    logic        winc;
    logic [7:0]  wd;
    logic [3:0]  rdy;
    logic [1:0]  g;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(logic r, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                              logic wf, logic ew, logic [7:0] ewd, logic [3:0] er,
                              logic [1:0] eg, logic eb);
    vec_t t;
    t.rst = r; t.v = v; t.l = l; t.d = d; t.wf = wf;
    t.winc = ew; t.wd = ewd; t.rdy = er; t.g = eg; t.busy = eb;
    vecs.push_back(t);
  endfunction

  logic       cap_busy [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] cap_g    [9] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1};

  initial begin
    rst = 1'b1; valid = '0; last = '0; data = '0; wfull = 1'b0;

    // single packet from requester 2
    add(0, 4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 2'd0, 0);
    add(0, 4'h4, 4'h0, 32'h00A10000, 0, 0, 8'h00, 4'h0, 2'd0, 0);
    add(0, 4'h4, 4'h0, 32'h00A10000, 0, 1, 8'hA1, 4'h4, 2'd2, 1);
    add(0, 4'h4, 4'h0, 32'h00A20000, 0, 1, 8'hA2, 4'h4, 2'd2, 1);
    add(0, 4'h4, 4'h4, 32'h00A30000, 0, 1, 8'hA3, 4'h4, 2'd2, 1);
    add(0, 4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 2'd2, 0);
    add(1, 4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 2'd2, 0);
    // fairness: all valid, one-beat packets, order 0,1,2,3,0
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 0, 8'h00, 4'h0, 2'd0, 0);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 1, 8'h11, 4'h1, 2'd0, 1);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 0, 8'h00, 4'h0, 2'd0, 0);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 1, 8'h22, 4'h2, 2'd1, 1);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 0, 8'h00, 4'h0, 2'd1, 0);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 1, 8'h33, 4'h4, 2'd2, 1);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 0, 8'h00, 4'h0, 2'd2, 0);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 1, 8'h44, 4'h8, 2'd3, 1);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 0, 8'h00, 4'h0, 2'd3, 0);
    add(0, 4'hF, 4'hF, 32'h44332211, 0, 1, 8'h11, 4'h1, 2'd0, 1);
    // backpressure on a 5-beat packet from requester 1, then last held under wfull
    add(0, 4'h2, 4'h0, 32'h0000B100, 0, 0, 8'h00, 4'h0, 2'd0, 0);
    add(0, 4'h2, 4'h0, 32'h0000B100, 0, 1, 8'hB1, 4'h2, 2'd1, 1);
    add(0, 4'h2, 4'h0, 32'h0000B200, 0, 1, 8'hB2, 4'h2, 2'd1, 1);
    for (int i = 0; i < 4; i++)
      add(0, 4'h2, 4'h0, 32'h0000B300, 1, 0, 8'hB3, 4'h0, 2'd1, 1);
    add(0, 4'h2, 4'h0, 32'h0000B300, 0, 1, 8'hB3, 4'h2, 2'd1, 1);
    add(0, 4'h2, 4'h0, 32'h0000B400, 0, 1, 8'hB4, 4'h2, 2'd1, 1);
    add(0, 4'h2, 4'h2, 32'h0000B500, 1, 0, 8'hB5, 4'h0, 2'd1, 1);
    add(0, 4'h2, 4'h2, 32'h0000B500, 0, 1, 8'hB5, 4'h2, 2'd1, 1);
    // granted requester 2 drops valid while requester 3 waits
    add(0, 4'hC, 4'h0, 32'hD0C10000, 0, 0, 8'h00, 4'h0, 2'd1, 0);
    add(0, 4'hC, 4'h0, 32'hD0C10000, 0, 1, 8'hC1, 4'h4, 2'd2, 1);
    for (int i = 0; i < 3; i++)
      add(0, 4'h8, 4'h0, 32'hD0C20000, 0, 0, 8'hC2, 4'h4, 2'd2, 1);
    add(0, 4'hC, 4'h0, 32'hD0C20000, 0, 1, 8'hC2, 4'h4, 2'd2, 1);
    add(0, 4'hC, 4'h4, 32'hD0C30000, 0, 1, 8'hC3, 4'h4, 2'd2, 1);
    add(0, 4'h8, 4'h8, 32'hD1000000, 0, 0, 8'h00, 4'h0, 2'd2, 0);
    add(0, 4'h8, 4'h8, 32'hD1000000, 0, 1, 8'hD1, 4'h8, 2'd3, 1);
    // reset during beat 2 of requester 1, then arbitration restarts at 0
    add(0, 4'h2, 4'h0, 32'h0000E100, 0, 0, 8'h00, 4'h0, 2'd3, 0);
    add(0, 4'h2, 4'h0, 32'h0000E100, 0, 1, 8'hE1, 4'h2, 2'd1, 1);
    add(1, 4'h2, 4'h0, 32'h0000E200, 0, 1, 8'hE2, 4'h2, 2'd1, 1);
    add(0, 4'h3, 4'h1, 32'h0000E3F1, 0, 0, 8'h00, 4'h0, 2'd0, 0);
    add(0, 4'h3, 4'h1, 32'h0000E3F1, 0, 1, 8'hF1, 4'h1, 2'd0, 1);
    add(0, 4'h0, 4'h0, 32'h00000000, 0, 0, 8'h00, 4'h0, 2'd0, 0);

    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; valid = vecs[i].v; last = vecs[i].l;
      data = vecs[i].d;  wfull = vecs[i].wf;
      #2;
      checks++;
      if (bus_m.winc !== vecs[i].winc || bus_m.wdata !== vecs[i].wd ||
          bus_m.req_ready !== vecs[i].rdy || bus_m.grant_id !== vecs[i].g ||
          bus_m.busy !== vecs[i].busy) begin
        errors++;
        $display("FAIL vec%0d: got winc=%b wdata=%h ready=%b grant=%0d busy=%b, want winc=%b wdata=%h ready=%b grant=%0d busy=%b",
                 i, bus_m.winc, bus_m.wdata, bus_m.req_ready, bus_m.grant_id, bus_m.busy,
                 vecs[i].winc, vecs[i].wd, vecs[i].rdy, vecs[i].g, vecs[i].busy);
      end
    end

    // burst cap of 4: requester 1 streams without last, requester 3 waits
    @(negedge clk);
    rst = 1'b1; valid = '0; last = '0; data = '0; wfull = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rst = 1'b0; valid = 4'hA; last = 4'h8; data = 32'h5A00A500 + c;
      #2;
      checks++;
      if (bus_c.busy !== cap_busy[c] || bus_c.winc !== cap_busy[c] ||
          bus_c.grant_id !== cap_g[c]) begin
        errors++;
        $display("FAIL cap%0d: got busy=%b winc=%b grant=%0d, want busy=%b winc=%b grant=%0d",
                 c, bus_c.busy, bus_c.winc, bus_c.grant_id, cap_busy[c], cap_busy[c], cap_g[c]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
